// File: rtl/key_scan_multi.sv
// key_scan_multi: per-key synchroniser, debouncer and press/release/long/repeat event generator
module key_scan_multi #(
  parameter int KEY_NUM      = 3,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat,
  output logic               key_flag,
  output logic [KEY_NUM-1:0] key_value
);
  localparam int MX = LONG_CYC > DEBOUNCE_CYC ? (LONG_CYC > REPEAT_CYC ? LONG_CYC : REPEAT_CYC)
                                              : (DEBOUNCE_CYC > REPEAT_CYC ? DEBOUNCE_CYC : REPEAT_CYC);
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, PRESS_DB, HELD, REPEAT, LONGHELD, RELEASE_DB} state_t;
  logic [KEY_NUM-1:0] s1, s2, press_nxt;
  // synchronisers carry the pressed level, so reset value 0 is the released level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_in ^ {KEY_NUM{ACTIVE_LOW != 0}};
      s2 <= s1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_flag  <= 1'b0;
      key_value <= '0;
    end else begin
      key_flag <= |press_nxt;
      if (|press_nxt) key_value <= press_nxt;
    end
  genvar k;
  generate
    for (k = 0; k < KEY_NUM; k++) begin : g_key
      state_t st, ret;
      logic [CW-1:0] db, hold, rep;
      logic ks, kp, kr, kl, krp;
      assign press_nxt[k]   = st == PRESS_DB && s2[k] && db == CW'(DEBOUNCE_CYC - 1);
      assign key_state[k]   = ks;
      assign key_press[k]   = kp;
      assign key_release[k] = kr;
      assign key_long[k]    = kl;
      assign key_repeat[k]  = krp;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          st   <= IDLE;
          ret  <= HELD;
          db   <= '0;
          hold <= '0;
          rep  <= '0;
          ks   <= 1'b0;
          kp   <= 1'b0;
          kr   <= 1'b0;
          kl   <= 1'b0;
          krp  <= 1'b0;
        end else begin
          kp  <= press_nxt[k];
          kr  <= 1'b0;
          kl  <= 1'b0;
          krp <= 1'b0;
          case (st)
            IDLE: if (s2[k]) begin
              st <= PRESS_DB;
              db <= CW'(1);
            end
            PRESS_DB: if (!s2[k]) st <= IDLE;
              else if (press_nxt[k]) begin
                st   <= HELD;
                ks   <= 1'b1;
                hold <= '0;
              end else db <= db + CW'(1);
            HELD, REPEAT, LONGHELD: if (!s2[k]) begin
              // leaving for release debounce freezes hold/repeat counters until we return
              st  <= RELEASE_DB;
              ret <= st;
              db  <= CW'(1);
            end else if (st == HELD) begin
              if (hold == CW'(LONG_CYC - 1)) begin
                kl  <= 1'b1;
                st  <= REPEAT_EN != 0 ? REPEAT : LONGHELD;
                rep <= '0;
              end else hold <= hold + CW'(1);
            end else if (st == REPEAT) begin
              krp <= rep == CW'(REPEAT_CYC - 1);
              rep <= rep == CW'(REPEAT_CYC - 1) ? '0 : rep + CW'(1);
            end
            RELEASE_DB: if (s2[k]) st <= ret;
              else if (db == CW'(DEBOUNCE_CYC - 1)) begin
                st <= IDLE;
                ks <= 1'b0;
                kr <= 1'b1;
              end else db <= db + CW'(1);
            default: st <= IDLE;
          endcase
        end
    end
  endgenerate
endmodule
